// File: rtl/cp_if_stage.sv
// -----------------------------------------------------------------------------
// cp_if_stage : instruction fetch stage of the cprv32g pipeline.
//
// Owns the PC and issues in-order, word-aligned fetches to the instruction
// memory. Returned words are buffered in a small FIFO and handed to the ID
// stage over a valid/ready handshake. A redirect from EX flushes the FIFO,
// arms a drop counter for responses still in flight, and restarts fetch at
// the (word-aligned) target.
//
// Parameters
//   RESET_PC    first fetch address after reset (bits [1:0] must be 0)
//   FIFO_DEPTH  fetch buffer entries (power of two, >= 2); also caps the
//               number of requests in flight
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   imem_req_*          fetch request channel (valid/ready, byte address)
//   imem_resp_*         in-order fetch responses, no backpressure
//   instr_*_id_*        instruction channel to ID (valid/ready, data)
//   redirect_*          PC redirect from EX
//   instr_pc_id_o       (CP_IF_PC_OUT_EN only) PC of the presented instruction
//
// Build option
//   CP_IF_PC_OUT_EN     when defined, each FIFO entry carries its fetch PC and
//                       the instr_pc_id_o port is present
// -----------------------------------------------------------------------------
module cp_if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        instr_valid_id_o,
  input  logic        instr_ready_id_i,
  output logic [31:0] instr_data_id_o,
`ifdef CP_IF_PC_OUT_EN
  output logic [31:0] instr_pc_id_o,
`endif
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  // One fetch buffer entry; the PC field exists only with the PC output option.
  typedef struct packed {
`ifdef CP_IF_PC_OUT_EN
    logic [31:0] pc;
`endif
    logic [31:0] instr;
  } entry_t;

  // Architectural state
  logic [31:0]      pc_q,       pc_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0] out_cnt_q,  out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  entry_t           fifo_mem [FIFO_DEPTH];

  // Per-cycle decode
  logic   credit;
  logic   fifo_empty;
  logic   req_fire;
  logic   resp_ok;
  logic   drop_now;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head_entry;

  // The two low bits of a redirect target are forced to zero.
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc_i[1:0];

  // Issue credit: stale (to-be-dropped) requests are still counted in out_cnt.
  assign credit     = (SUM_W'(out_cnt_q) + SUM_W'(fifo_cnt_q)) < SUM_W'(FIFO_DEPTH);
  assign fifo_empty = (fifo_cnt_q == '0);

  // Memory request side
  assign imem_req_valid_o = rst_n & credit & ~redirect_valid_i;
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok  = imem_resp_valid_i & (out_cnt_q != '0);
  assign drop_now = resp_ok & (drop_cnt_q != '0);
  assign push     = resp_ok & ~drop_now & ~redirect_valid_i;

  // ID side: head of FIFO only, no bypass from the response port.
  assign head_entry       = fifo_mem[rd_ptr_q];
  assign instr_valid_id_o = rst_n & ~fifo_empty & ~redirect_valid_i;
  assign instr_data_id_o  = head_entry.instr;
  assign pop              = instr_valid_id_o & instr_ready_id_i;

  // Next-state logic
  always_comb begin
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    drop_cnt_d = drop_cnt_q;

    // Outstanding count tracks every accepted request and every response.
    out_cnt_d  = out_cnt_q + CNT_W'(req_fire) - CNT_W'(resp_ok);

    if (redirect_valid_i) begin
      // New target; everything still in flight becomes stale.
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      rd_ptr_d   = wr_ptr_q;
      fifo_cnt_d = '0;
      drop_cnt_d = out_cnt_d;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (drop_now) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage; contents are qualified by fifo_cnt_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

`ifdef CP_IF_PC_OUT_EN
  // In-flight PC queue: one entry per outstanding request, consumed by every
  // response (kept or dropped), so it stays aligned across redirects.
  logic [31:0]      flight_pc_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] flight_wr_q, flight_wr_d;
  logic [PTR_W-1:0] flight_rd_q, flight_rd_d;

  always_comb begin
    flight_wr_d = flight_wr_q;
    flight_rd_d = flight_rd_q;
    if (req_fire) begin
      flight_wr_d = flight_wr_q + PTR_W'(1);
    end
    if (resp_ok) begin
      flight_rd_d = flight_rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flight_wr_q <= '0;
      flight_rd_q <= '0;
    end else begin
      flight_wr_q <= flight_wr_d;
      flight_rd_q <= flight_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && req_fire) begin
      flight_pc_mem[flight_wr_q] <= pc_q;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = flight_pc_mem[flight_rd_q];
    push_entry.instr = imem_resp_data_i;
  end

  assign instr_pc_id_o = head_entry.pc;
`else
  always_comb begin
    push_entry       = '0;
    push_entry.instr = imem_resp_data_i;
  end
`endif

endmodule

// File: tb/tb_cp_if_stage.sv
// -----------------------------------------------------------------------------
// tb_cp_if_stage : directed bench for cp_if_stage.
// A small memory model answers every accepted request one cycle later (unless
// held) with word = address ^ MASK, so every returned word identifies its PC.
// -----------------------------------------------------------------------------
module tb_cp_if_stage;

  localparam logic [31:0] MASK = 32'h5A5A_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        id_ready;
  logic        redir;
  logic [31:0] redir_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        ivalid;
  logic [31:0] idata;
`ifdef CP_IF_PC_OUT_EN
  logic [31:0] ipc;
`endif

  cp_if_stage #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_resp_valid_i(resp_valid),
    .imem_resp_data_i (resp_data),
    .instr_valid_id_o (ivalid),
    .instr_ready_id_i (id_ready),
    .instr_data_id_o  (idata),
`ifdef CP_IF_PC_OUT_EN
    .instr_pc_id_o    (ipc),
`endif
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];       // accepted, not yet answered request addresses
  logic [31:0] req_log[$];  // every accepted request address
  logic [31:0] id_log[$];   // every word accepted by ID
  logic        mem_hold;

  logic        s_rv;
  logic        s_iv;
  logic [31:0] s_addr;
  logic [31:0] s_id;

  typedef struct {
    logic        rst_n;
    logic        req_ready;
    logic        id_ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive the memory response, sample outputs at negedge,
  // log handshakes, then advance past the posedge.
  task automatic tick();
    if (!rst_n) mq.delete();
    if (rst_n && !mem_hold && mq.size() > 0) begin
      resp_valid = 1'b1;
      resp_data  = mq.pop_front() ^ MASK;
    end else begin
      resp_valid = 1'b0;
      resp_data  = '0;
    end
    @(negedge clk);
    s_rv   = req_valid;
    s_addr = req_addr;
    s_iv   = ivalid;
    s_id   = idata;
    if (s_rv && req_ready) begin
      mq.push_back(s_addr);
      req_log.push_back(s_addr);
    end
    if (s_iv && id_ready) id_log.push_back(s_id);
`ifdef CP_IF_PC_OUT_EN
    if (s_iv) chk("pc_out", ipc, s_id ^ MASK);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    redir     = 1'b0;
    redir_pc  = '0;
    req_ready = 1'b1;
    id_ready  = 1'b1;
    mem_hold  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    req_log.delete();
    id_log.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_ready  = 1'b1;
    id_ready   = 1'b1;
    redir      = 1'b0;
    redir_pc   = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    mem_hold   = 1'b0;

    // Reset, then free-running fetch from 0 with memory always ready.
    // Conservative credit: 2 entries, each busy for 3 cycles.
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4,  1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h5A5A_0000};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8,  1'b1, 32'h5A5A_0004};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC,  1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h5A5A_0008};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h5A5A_000C};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h14, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h5A5A_0010};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h18, 1'b1, 32'h5A5A_0014};

    for (int i = 0; i < 12; i++) begin
      rst_n     = vecs[i].rst_n;
      req_ready = vecs[i].req_ready;
      id_ready  = vecs[i].id_ready;
      redir     = vecs[i].redir;
      redir_pc  = vecs[i].redir_pc;
      tick();
      chk($sformatf("vec%0d req_valid", i), 32'(s_rv), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) chk($sformatf("vec%0d req_addr", i), s_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d instr_valid", i), 32'(s_iv), 32'(vecs[i].exp_iv));
      if (vecs[i].exp_iv) chk($sformatf("vec%0d instr_data", i), s_id, vecs[i].exp_data);
    end

    // ID stalled for 10 cycles: two requests, first word held, nothing lost.
    do_reset();
    id_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k >= 2) begin
        chk($sformatf("stall%0d valid", k), 32'(s_iv), 32'd1);
        chk($sformatf("stall%0d data", k), s_id, 32'h5A5A_0000);
      end
    end
    chk("stall req_count", 32'(req_log.size()), 32'd2);
    id_ready = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("stall id0", q_at(id_log, 0), 32'h5A5A_0000);
    chk("stall id1", q_at(id_log, 1), 32'h5A5A_0004);
    chk("stall id2", q_at(id_log, 2), 32'h5A5A_0008);
    chk("stall id3", q_at(id_log, 3), 32'h5A5A_000C);

    // Memory not ready for 3 cycles while 0x8 is on the bus.
    do_reset();
    tick();
    tick();
    tick();
    req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mstall%0d valid", k), 32'(s_rv), 32'd1);
      chk($sformatf("mstall%0d addr", k), s_addr, 32'h8);
    end
    req_ready = 1'b1;
    tick();
    chk("mstall resume addr", s_addr, 32'h8);
    tick();
    chk("mstall next valid", 32'(s_rv), 32'd1);
    chk("mstall next addr", s_addr, 32'hC);
    chk("mstall req2", q_at(req_log, 2), 32'h8);

    // Redirect to 0x100 with two requests in flight.
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    redir    = 1'b1;
    redir_pc = 32'h100;
    tick();
    chk("redir req_valid", 32'(s_rv), 32'd0);
    chk("redir instr_valid", 32'(s_iv), 32'd0);
    redir    = 1'b0;
    mem_hold = 1'b0;
    tick();
    chk("redir no credit", 32'(s_rv), 32'd0);
    tick();
    chk("redir new valid", 32'(s_rv), 32'd1);
    chk("redir new addr", s_addr, 32'h100);
    for (int k = 0; k < 4; k++) tick();
    chk("redir first id", q_at(id_log, 0), 32'h100 ^ MASK);

    // Redirect to 0x103 in the same cycle as a response.
    do_reset();
    tick();
    redir    = 1'b1;
    redir_pc = 32'h103;
    tick();
    chk("redir_resp req_valid", 32'(s_rv), 32'd0);
    redir = 1'b0;
    tick();
    chk("redir_resp addr", s_addr, 32'h100);
    chk("redir_resp instr_valid", 32'(s_iv), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("redir_resp first id", q_at(id_log, 0), 32'h100 ^ MASK);

    // Back-to-back redirects with responses outstanding: last target wins.
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    redir    = 1'b1;
    redir_pc = 32'h200;
    tick();
    mem_hold = 1'b0;
    redir_pc = 32'h300;
    tick();
    redir = 1'b0;
    tick();
    chk("b2b valid", 32'(s_rv), 32'd1);
    chk("b2b addr", s_addr, 32'h300);
    for (int k = 0; k < 4; k++) tick();
    chk("b2b first id", q_at(id_log, 0), 32'h300 ^ MASK);

    // PC wrap from 0xFFFFFFFC to 0x0.
    do_reset();
    redir    = 1'b1;
    redir_pc = 32'hFFFF_FFFC;
    tick();
    redir = 1'b0;
    tick();
    chk("wrap addr0", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap addr1", s_addr, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    chk("wrap id0", q_at(id_log, 0), 32'hFFFF_FFFC ^ MASK);
    chk("wrap id1", q_at(id_log, 1), 32'h0 ^ MASK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
